// File: rtl/fl_div32.sv
// Iterative IEEE-754 single-precision divider (quotient = in0 / in1), restoring radix-2, fixed 29-cycle latency.
// Optional exception flags output enabled by defining FL_DIV_FLAGS_EN.
module fl_div32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient
`ifdef FL_DIV_FLAGS_EN
   ,
   output logic [4:0]  flags
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_OUT} state_t;

   // Round-to-nearest-even on q[25:0] = 24 significand bits, guard, round; result may carry to 2^24.
   function automatic logic [24:0] rne_round(input logic [25:0] q, input logic sticky);
      logic inc;
      inc = q[1] & (q[0] | sticky | q[2]);
      return {1'b0, q[25:2]} + {24'd0, inc};
   endfunction

   function automatic logic [31:0] sat_pack(input logic sign, input logic signed [9:0] e,
                                            input logic [22:0] frac);
      if (e >= 10'sd255)
         return {sign, 8'hFF, 23'd0};
      else if (e <= 10'sd0)
         return {sign, 31'd0};
      else
         return {sign, e[7:0], frac};
   endfunction

   state_t             state, state_nxt;
   logic [31:0]        a_r, b_r;
   logic               sign_r;
   logic signed [9:0]  e_r;
   logic [24:0]        rem_r;
   logic [23:0]        div_r;
   logic [25:0]        q_r;
   logic [4:0]         cnt_r;
   logic               spec_r;
   logic [31:0]        spec_res_r;
   logic [31:0]        res_r;

   logic [7:0]         ea, eb;
   logic               za, zb, ia, ib, na, nb;
   logic               inval, to_inf, to_zero;
   logic [23:0]        ma, mb;
   logic signed [9:0]  e_raw;

   assign ea      = a_r[30:23];
   assign eb      = b_r[30:23];
   assign za      = (ea == 8'h00);
   assign zb      = (eb == 8'h00);
   assign ia      = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
   assign ib      = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
   assign na      = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
   assign nb      = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
   assign inval   = na | nb | (za & zb) | (ia & ib);
   assign to_inf  = !inval & (ia | zb);
   assign to_zero = !inval & !to_inf & (za | ib);
   assign ma      = {1'b1, a_r[22:0]};
   assign mb      = {1'b1, b_r[22:0]};
   assign e_raw   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

   logic               q_bit;
   logic [24:0]        rem_dif, rem_nxt;

   assign q_bit   = (rem_r >= {1'b0, div_r});
   assign rem_dif = q_bit ? rem_r - {1'b0, div_r} : rem_r;
   assign rem_nxt = rem_dif << 1;

   logic               sticky;
   logic [24:0]        sig_rnd;
   logic [22:0]        frac_rnd;
   logic signed [9:0]  e_rnd;

   assign sticky   = |rem_r;
   assign sig_rnd  = rne_round(q_r, sticky);
   assign frac_rnd = sig_rnd[24] ? sig_rnd[23:1] : sig_rnd[22:0];
   assign e_rnd    = e_r + $signed({9'd0, sig_rnd[24]});

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_UNPACK;
         S_UNPACK: state_nxt = S_DIVIDE;
         S_DIVIDE: if (cnt_r == 5'd0) state_nxt = S_ROUND;
         S_ROUND:  state_nxt = S_OUT;
         S_OUT:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r <= '0; b_r <= '0; sign_r <= 1'b0; e_r <= '0;
         rem_r <= '0; div_r <= '0; q_r <= '0; cnt_r <= '0;
         spec_r <= 1'b0; spec_res_r <= '0; res_r <= '0;
         quotient <= '0; done <= 1'b0;
      end else begin
         done <= (state == S_OUT);
         case (state)
            S_IDLE: if (start) begin
               a_r <= in0;
               b_r <= in1;
            end
            S_UNPACK: begin
               sign_r <= a_r[31] ^ b_r[31];
               div_r  <= mb;
               q_r    <= '0;
               cnt_r  <= 5'd25;
               // Pre-align so the quotient falls in [1,2) and q[25] is always set.
               if (ma < mb) begin
                  rem_r <= {ma, 1'b0};
                  e_r   <= e_raw - 10'sd1;
               end else begin
                  rem_r <= {1'b0, ma};
                  e_r   <= e_raw;
               end
               spec_r <= inval | to_inf | to_zero;
               if (inval)       spec_res_r <= 32'h7FC00000;
               else if (to_inf) spec_res_r <= {a_r[31] ^ b_r[31], 8'hFF, 23'd0};
               else             spec_res_r <= {a_r[31] ^ b_r[31], 31'd0};
            end
            S_DIVIDE: begin
               q_r   <= {q_r[24:0], q_bit};
               rem_r <= rem_nxt;
               cnt_r <= cnt_r - 5'd1;
            end
            S_ROUND: res_r <= spec_r ? spec_res_r : sat_pack(sign_r, e_rnd, frac_rnd);
            S_OUT:   quotient <= res_r;
            default: ;
         endcase
      end
   end

`ifdef FL_DIV_FLAGS_EN
   logic [4:0] spec_flg_r, res_flg_r;
   logic       ovf, unf, inx;

   assign ovf = (e_rnd >= 10'sd255);
   assign unf = (e_rnd <= 10'sd0);
   assign inx = q_r[1] | q_r[0] | sticky;

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_flg_r <= '0;
         res_flg_r  <= '0;
         flags      <= '0;
      end else begin
         case (state)
            S_IDLE:   if (start) flags <= '0;
            S_UNPACK: spec_flg_r <= {inval, !inval & !za & !ia & zb, 3'b000};
            S_ROUND:  res_flg_r  <= spec_r ? spec_flg_r : {2'b00, ovf, unf, inx | ovf | unf};
            S_OUT:    flags <= res_flg_r;
            default:  ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_fl_div32.sv
// Directed bench for fl_div32: integer-arithmetic reference model plus hand-computed literals.
// Define FL_DIV_FLAGS_EN to also check the flags port.
module tb_fl_div32;

   logic        clk, rst, start;
   logic [31:0] in0, in1;
   logic        busy, done;
   logic [31:0] quotient;
`ifdef FL_DIV_FLAGS_EN
   logic [4:0]  flags;
`endif

   fl_div32 dut (
      .clk(clk), .rst(rst), .start(start), .in0(in0), .in1(in1),
      .busy(busy), .done(done), .quotient(quotient)
`ifdef FL_DIV_FLAGS_EN
      , .flags(flags)
`endif
   );

   typedef struct {
      logic [31:0] q;
      logic [4:0]  f;
      logic [31:0] lq;
      logic        lq_v;
      logic [4:0]  lf;
      logic        lf_v;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   tests = 0;
   int   fails = 0;
   int   edge_n = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000ns");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference: exact quotient from a wide integer divide, then RNE by comparing the tail to one half.
   function automatic logic [36:0] model_div(input logic [31:0] a, input logic [31:0] b);
      logic [7:0]  xa, xb;
      logic        za, zb, ia, ib, na, nb, s, up, inx;
      logic [63:0] num, den, qq, rr, tail, half, sig;
      int          sh, e;
      xa = a[30:23]; xb = b[30:23];
      za = (xa == 8'h00); zb = (xb == 8'h00);
      ia = (xa == 8'hFF) && (a[22:0] == 23'd0);
      ib = (xb == 8'hFF) && (b[22:0] == 23'd0);
      na = (xa == 8'hFF) && (a[22:0] != 23'd0);
      nb = (xb == 8'hFF) && (b[22:0] != 23'd0);
      s  = a[31] ^ b[31];
      if (na || nb || (za && zb) || (ia && ib)) return {5'b10000, 32'h7FC00000};
      if (ia) return {5'b00000, s, 8'hFF, 23'd0};
      if (zb) return {5'b01000, s, 8'hFF, 23'd0};
      if (za || ib) return {5'b00000, s, 31'd0};
      num = {40'd0, 1'b1, a[22:0]} << 40;
      den = {40'd0, 1'b1, b[22:0]};
      qq  = num / den;
      rr  = num % den;
      e   = int'(xa) - int'(xb) + 127;
      if (qq >= (64'd1 << 40)) sh = 17;
      else begin
         sh = 16;
         e  = e - 1;
      end
      sig  = qq >> sh;
      tail = qq & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      up   = (tail > half) || ((tail == half) && ((rr != 64'd0) || sig[0]));
      inx  = (tail != 64'd0) || (rr != 64'd0);
      sig  = sig + {63'd0, up};
      if (sig == (64'd1 << 24)) begin
         sig = sig >> 1;
         e   = e + 1;
      end
      if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
      if (e <= 0)   return {5'b00011, s, 31'd0};
      return {4'b0000, inx, s, e[7:0], sig[22:0]};
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 with quotient %h, required no done", quotient);
         end else begin
            cur = exp_q.pop_front();
            chk("quotient_model", quotient, cur.q);
            if (cur.lq_v) chk("quotient_literal", quotient, cur.lq);
            chk("latency", 32'(edge_n - cur.acc), 32'd29);
`ifdef FL_DIV_FLAGS_EN
            chk("flags_model", 32'(flags), 32'(cur.f));
            if (cur.lf_v) chk("flags_literal", 32'(flags), 32'(cur.lf));
`endif
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic drive_start(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] lq, input logic lqv,
                              input logic [4:0] lf, input logic lfv);
      exp_t       x;
      logic [36:0] m;
      m      = model_div(a, b);
      x.q    = m[31:0];
      x.f    = m[36:32];
      x.lq   = lq;
      x.lq_v = lqv;
      x.lf   = lf;
      x.lf_v = lfv;
      x.acc  = edge_n + 1;
      exp_q.push_back(x);
      start = 1'b1;
      in0   = a;
      in1   = b;
      @(negedge clk);
      start = 1'b0;
`ifdef FL_DIV_FLAGS_EN
      chk("flags_cleared_on_start", 32'(flags), 32'd0);
`endif
   endtask

   task automatic wait_done(input int max);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done in %0d cycles, required done", max);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lq, input logic lqv,
                         input logic [4:0] lf, input logic lfv);
      @(negedge clk);
      drive_start(a, b, lq, lqv, lf, lfv);
      wait_done(40);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in0 = '0; in1 = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_quotient", quotient, 32'd0);
`ifdef FL_DIV_FLAGS_EN
      chk("reset_flags", 32'(flags), 32'd0);
`endif
      rst = 1'b0;

      // 6.0 / 2.0 with busy profile across the whole operation
      @(negedge clk);
      drive_start(32'h40C00000, 32'h40000000, 32'h40400000, 1'b1, 5'b00000, 1'b1);
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk);
         chk("busy_in_flight", 32'(busy), 32'd1);
         chk("done_early", 32'(done), 32'd0);
      end
      @(negedge clk);
      chk("busy_done_cycle", 32'(busy), 32'd0);
      chk("done_pulse", 32'(done), 32'd1);

      run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b1, 5'b00001, 1'b1);
      run_op(32'hBF800000, 32'h40000000, 32'hBF000000, 1'b1, 5'b00000, 1'b1);
      run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 5'b01000, 1'b1);
      run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 5'b10000, 1'b1);
      run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1, 5'b00000, 1'b1);
      run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 5'b10000, 1'b1);
      run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b1, 5'b00101, 1'b1);
      run_op(32'h00800000, 32'h40000000, 32'h00000000, 1'b1, 5'b00011, 1'b1);
      run_op(32'h00400000, 32'h3F800000, 32'h00000000, 1'b1, 5'b00000, 1'b1);
      run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1, 5'b00000, 1'b1);
      run_op(32'h00000000, 32'hC0000000, 32'h80000000, 1'b1, 5'b00000, 1'b1);
      run_op(32'h3F800000, 32'hFF800000, 32'h80000000, 1'b1, 5'b00000, 1'b1);
      run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 5'b10000, 1'b1);
      run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 5'b00101, 1'b1);
      run_op(32'h00800000, 32'h7F000000, 32'h00000000, 1'b1, 5'b00011, 1'b1);
      run_op(32'h40490FDB, 32'h402DF854, 32'h0, 1'b0, 5'b0, 1'b0);
      run_op(32'hC1200000, 32'h3DCCCCCD, 32'h0, 1'b0, 5'b0, 1'b0);
      run_op(32'h3FFFFFFF, 32'h3F800001, 32'h0, 1'b0, 5'b0, 1'b0);

      // start while busy is ignored
      @(negedge clk);
      drive_start(32'h41200000, 32'h40A00000, 32'h40000000, 1'b1, 5'b00000, 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1; in0 = 32'h3F800000; in1 = 32'h40400000;
      @(negedge clk);
      start = 1'b0;
      wait_done(40);
      repeat (35) @(negedge clk);

      // back-to-back: new start in the done cycle
      @(negedge clk);
      drive_start(32'h40800000, 32'h40000000, 32'h40000000, 1'b1, 5'b00000, 1'b1);
      wait_done(40);
      drive_start(32'h40400000, 32'h3F800000, 32'h40400000, 1'b1, 5'b00000, 1'b1);
      wait_done(40);

      // reset mid-operation aborts with no done
      @(negedge clk);
      drive_start(32'h40C00000, 32'h40000000, 32'h40400000, 1'b1, 5'b00000, 1'b1);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
